// File: rtl/countdown_display_ctrl_pkg.sv
// Shared definitions for the countdown display sequencer: state encodings
// understood by the downstream display decoder, the BCD value record and
// small helpers for clamping and decrementing BCD values.
package countdown_display_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  localparam logic [3:0] MAX_UNITS = 4'd9;

  typedef struct packed {
    logic [1:0] dozens;
    logic [3:0] units;
  } bcd_value_t;

  localparam bcd_value_t BCD_ZERO = '{dozens: 2'd0, units: 4'd0};

  // Units digits above 9 are not valid BCD, so they saturate at 9.
  function automatic logic [3:0] clamp_units(input logic [3:0] raw_units);
    return (raw_units > MAX_UNITS) ? MAX_UNITS : raw_units;
  endfunction

  // One-step BCD decrement that saturates at 00 instead of wrapping.
  function automatic bcd_value_t bcd_decrement(input bcd_value_t value);
    bcd_value_t result;
    result = value;
    if (value.units != 4'd0) begin
      result.units = value.units - 4'd1;
    end else if (value.dozens != 2'd0) begin
      result.units  = MAX_UNITS;
      result.dozens = value.dozens - 2'd1;
    end
    return result;
  endfunction

  function automatic logic bcd_is_zero(input bcd_value_t value);
    return (value.dozens == 2'd0) && (value.units == 4'd0);
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Button conditioner: brings an asynchronous active-high level into the
// clock domain with a two-flop synchroniser and turns each rising edge into
// a single-cycle pulse. A button held down produces exactly one pulse.
module btn_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Synchroniser chain plus a delayed copy of its output for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      prev_q <= sync_q[1];
    end
  end

  assign pulse = sync_q[1] & ~prev_q;

endmodule

// File: rtl/countdown_display_ctrl.sv
// Countdown sequencer feeding the 4-digit display group. Holds a 0..39 BCD
// value, counts it down once per second (second derived from the scan clock
// by a prescaler) and reports IDLE/RUN/PAUSE/DONE. Every output is a flop;
// tick and done are registered from next-state values so they line up with
// the state and prescaler registers they describe.
module countdown_display_ctrl
  import countdown_display_ctrl_pkg::*;
#(
  parameter int CLK_HZ    = 840,
  parameter int TICK_HZ   = 1,
  parameter int DONE_HOLD = 5
) (
  input  logic       _840_Hz,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_load,
  input  logic [1:0] preset_dozens,
  input  logic [3:0] preset_units,
  output logic [1:0] state,
  output logic [1:0] dozens,
  output logic [3:0] units,
  output logic       tick,
  output logic       done
);

  localparam int DIV    = CLK_HZ / TICK_HZ;
  localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HOLD_W = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DONE_HOLD - 1);

  logic              start_pulse;
  logic              load_pulse;
  logic              start_evt;
  logic              load_evt;

  logic [1:0]        state_q, state_d;
  bcd_value_t        value_q, value_d;
  logic [CNT_W-1:0]  presc_q, presc_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              tick_q, tick_d;
  logic              done_q, done_d;
  bcd_value_t        preset_val;

  btn_edge_sync u_start_sync (
    .clk   (_840_Hz),
    .rst_n (rst_n),
    .btn   (btn_start),
    .pulse (start_pulse)
  );

  btn_edge_sync u_load_sync (
    .clk   (_840_Hz),
    .rst_n (rst_n),
    .btn   (btn_load),
    .pulse (load_pulse)
  );

  // A load landing in the same cycle as a start wins; that start is dropped.
  assign load_evt  = load_pulse;
  assign start_evt = start_pulse & ~load_pulse;

  assign preset_val = '{dozens: preset_dozens, units: clamp_units(preset_units)};

  // Next-state logic for the FSM, BCD value, prescaler and DONE hold counter.
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    presc_d = presc_q;
    hold_d  = hold_q;

    case (state_q)
      ST_IDLE: begin
        if (load_evt) begin
          value_d = preset_val;
        end else if (start_evt && !bcd_is_zero(value_q)) begin
          state_d = ST_RUN;
          presc_d = '0;
        end
      end

      ST_RUN: begin
        presc_d = (presc_q == CNT_LAST) ? '0 : presc_q + 1'b1;
        if (tick_q) begin
          value_d = bcd_decrement(value_q);
        end
        if (bcd_is_zero(value_d)) begin
          state_d = ST_DONE;
          presc_d = '0;
          hold_d  = '0;
        end else if (start_evt) begin
          state_d = ST_PAUSE;
        end
      end

      ST_PAUSE: begin
        if (load_evt) begin
          value_d = preset_val;
          state_d = ST_IDLE;
        end else if (start_evt) begin
          state_d = ST_RUN;
        end
      end

      ST_DONE: begin
        presc_d = (presc_q == CNT_LAST) ? '0 : presc_q + 1'b1;
        if (load_evt) begin
          value_d = preset_val;
          state_d = ST_IDLE;
        end else if (start_evt) begin
          state_d = ST_IDLE;
        end else if (tick_q) begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_IDLE;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        value_d = BCD_ZERO;
      end
    endcase

    if (state_d == ST_IDLE) begin
      presc_d = '0;
      hold_d  = '0;
    end
  end

  // Registered status flags derived from the next state and prescaler value.
  always_comb begin
    tick_d = ((state_d == ST_RUN) || (state_d == ST_DONE)) && (presc_d == CNT_LAST);
    done_d = (state_d == ST_DONE);
  end

  // State, value, timing and status registers.
  always_ff @(posedge _840_Hz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      value_q <= BCD_ZERO;
      presc_q <= '0;
      hold_q  <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign state  = state_q;
  assign dozens = value_q.dozens;
  assign units  = value_q.units;
  assign tick   = tick_q;
  assign done   = done_q;

endmodule
